// File: rtl/ram_stream_reader.sv
// Streams a contiguous RAM address range out on a valid/ready interface.
// The read address is registered and a 2-entry buffer decouples RAM reads from consumer backpressure.
module ram_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH:0]     remaining;
  logic [DATA_WIDTH-1:0]   data0, data1;
  logic                    last0, last1;
  logic [1:0]              count;
  logic                    capture, pop, accept, finish, tag;

  assign m_valid = (count != 2'd0);
  assign m_data  = data0;
  assign m_last  = last0;
  assign busy    = (state != IDLE);
  assign tag     = (remaining == (ADDR_WIDTH+1)'(1));

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    accept     = 1'b0;
    finish     = 1'b0;
    pop        = m_valid & m_ready;
    case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (length != '0) state_next = READ;
        end
      end
      READ: begin
        capture = (count < 2'd2) | pop;
        if (capture && tag) state_next = DRAIN;
      end
      DRAIN: begin
        if (pop && last0) begin
          state_next = IDLE;
          finish     = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      mem_addr  <= '0;
      remaining <= '0;
      data0     <= '0;
      data1     <= '0;
      last0     <= 1'b0;
      last1     <= 1'b0;
      count     <= 2'd0;
      done      <= 1'b0;
    end else begin
      state <= state_next;
      done  <= finish | (accept & (length == '0));

      if (accept && (length != '0)) begin
        mem_addr  <= base_addr;
        remaining <= length;
      end
      if (capture) begin
        mem_addr  <= mem_addr + ADDR_WIDTH'(1);
        remaining <= remaining - (ADDR_WIDTH+1)'(1);
      end

      // Entry 1 is zeroed whenever it drains, so an empty head always reads back as zero.
      case ({capture, pop})
        2'b10: begin
          if (count == 2'd0) begin
            data0 <= mem_data;
            last0 <= tag;
          end else begin
            data1 <= mem_data;
            last1 <= tag;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          data0 <= data1;
          last0 <= last1;
          data1 <= '0;
          last1 <= 1'b0;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            data0 <= mem_data;
            last0 <= tag;
          end else begin
            data0 <= data1;
            last0 <= last1;
            data1 <= mem_data;
            last1 <= tag;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader: a cycle table for the basic read-out plus
// per-cycle checked transfers for wrap, backpressure, zero/full length, reset and ignored starts.
module tb_ram_stream_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] base_addr;
  logic [8:0] length;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;
  logic       busy;
  logic       done;

  logic [7:0] mem [0:255];
  assign mem_data = mem[mem_addr];

  ram_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .mem_addr(mem_addr), .mem_data(mem_data), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       start;
    logic       ready;
    logic [7:0] addr;
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic       busy;
    logic       done;
  } vec_t;

  // mode 0: ready=1, mode 1: 1,0,0,1,0,1 pattern, mode 2: random ready
  task automatic run_xfer(input logic [7:0] base, input int len, input int mode, input bit inject);
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int adv = 0;
    int hs = 0;
    bit finished = 0;
    bit exp_cap, hs_now, last_hs, changed, stall;
    logic [7:0] prev_addr, prev_data;
    logic prev_last;
    logic [7:0] exp_d;
    logic [7:0] exp_end;
    base_addr = base;
    length    = 9'(len);
    start     = 1'b1;
    step();
    start = 1'b0;
    chk(mem_addr == base && busy && !m_valid && !done, "xfer_first_cycle",
        {m_valid, busy, done, mem_addr}, {3'b010, base});
    prev_addr = mem_addr;
    stall = 0;
    prev_data = '0;
    prev_last = 1'b0;
    for (int cyc = 0; cyc < 4 * len + 20; cyc++) begin
      case (mode)
        0: m_ready = 1'b1;
        1: m_ready = pat[cyc % 6];
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (inject && cyc == 2) begin
        start = 1'b1; base_addr = 8'h80; length = 9'd9;
      end else begin
        start = 1'b0;
      end
      chk(m_valid == (adv > hs), "valid_vs_inflight", m_valid, (adv > hs));
      if (stall)
        chk(m_valid && m_data == prev_data && m_last == prev_last, "stable_under_stall",
            {m_valid, m_last, m_data}, {1'b1, prev_last, prev_data});
      if (m_valid) begin
        exp_d = mem[8'(base + 8'(hs))];
        chk(m_data == exp_d && m_last == (hs == len - 1), "word_order",
            {m_last, m_data}, {(hs == len - 1), exp_d});
      end
      exp_cap = (adv < len) && (((adv - hs) < 2) || (m_valid && m_ready));
      hs_now  = m_valid && m_ready;
      last_hs = hs_now && m_last;
      stall   = m_valid && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
      step();
      changed = (mem_addr != prev_addr);
      chk(changed == exp_cap, "addr_advance", changed, exp_cap);
      if (changed) begin
        chk(mem_addr == 8'(prev_addr + 8'd1), "addr_step", mem_addr, 8'(prev_addr + 8'd1));
        adv++;
      end
      prev_addr = mem_addr;
      if (hs_now) hs++;
      if (last_hs) begin
        chk(done && !busy && !m_valid, "done_after_last", {done, busy, m_valid}, 3'b100);
        step();
        chk(!done && !busy && !m_valid, "done_one_cycle", {done, busy, m_valid}, 3'b000);
        finished = 1;
        break;
      end else begin
        chk(!done, "no_early_done", done, 1'b0);
      end
    end
    start = 1'b0;
    if (!finished) chk(1'b0, "xfer_timeout", hs, len);
    exp_end = 8'(base + 8'(len));
    chk(hs == len && mem_addr == exp_end, "xfer_count_end_addr", {hs[15:0], mem_addr}, {len[15:0], exp_end});
  endtask

  vec_t tbl [8];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 16);
    rst = 1'b0; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b1;
    step();
    step();
    rst = 1'b1;
    chk(!m_valid && !m_last && m_data == 8'h00 && !busy && !done && mem_addr == 8'h00,
        "reset_state", {m_valid, m_last, busy, done, m_data, mem_addr}, '0);

    // Basic read-out: base=4, length=4, ready held high
    tbl[0] = '{1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 8'h04, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 8'h05, 1'b1, 8'h14, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 8'h06, 1'b1, 8'h15, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 8'h07, 1'b1, 8'h16, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 8'h08, 1'b1, 8'h17, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    base_addr = 8'h04;
    length    = 9'd4;
    for (int c = 0; c < 8; c++) begin
      start   = tbl[c].start;
      m_ready = tbl[c].ready;
      chk({mem_addr, m_valid, m_data, m_last, busy, done} ==
          {tbl[c].addr, tbl[c].valid, tbl[c].data, tbl[c].last, tbl[c].busy, tbl[c].done},
          $sformatf("basic_cycle%0d", c),
          {mem_addr, m_valid, m_data, m_last, busy, done},
          {tbl[c].addr, tbl[c].valid, tbl[c].data, tbl[c].last, tbl[c].busy, tbl[c].done});
      step();
    end
    start = 1'b0;

    run_xfer(8'hFE, 4, 0, 1'b0);
    run_xfer(8'h00, 6, 1, 1'b0);
    run_xfer(8'h30, 17, 2, 1'b0);

    // Zero length
    base_addr = 8'h10; length = 9'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk(done && !busy && !m_valid, "zero_len_done", {done, busy, m_valid}, 3'b100);
    step();
    chk(!done && !busy && !m_valid, "zero_len_quiet", {done, busy, m_valid}, 3'b000);
    step();
    chk(!m_valid, "zero_len_no_valid", m_valid, 1'b0);

    run_xfer(8'h30, 256, 0, 1'b0);

    // Reset mid-transfer after the 3rd handshake of a length-8 transfer
    m_ready = 1'b1; base_addr = 8'h00; length = 9'd8; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    chk(m_valid && m_data == 8'h12, "pre_reset_third_word", {m_valid, m_data}, {1'b1, 8'h12});
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk(!m_valid && !busy && mem_addr == 8'h00 && !done && !m_last && m_data == 8'h00,
        "mid_reset_state", {m_valid, busy, done, m_last, mem_addr, m_data}, '0);
    step();
    chk(!done && !m_valid && !busy, "mid_reset_no_done", {done, m_valid, busy}, 3'b000);
    run_xfer(8'h20, 2, 0, 1'b0);

    // Start pulsed while busy must not disturb the running transfer
    run_xfer(8'h04, 5, 1, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
